dut_equiv_sequencer: RTL and testbench
======================================

Name: dut_equiv_sequencer

Overview:
- Clocked stimulus/compare controller for combinational equivalence runs.
- Drives one shared 50-bit stimulus bus into two DUT instances: the original netlist and the instruction-reduced netlist.
- Steps a 64-bit LFSR through a requested number of vectors and waits a settle interval per vector.
- Compares the two 30-bit results, and reports mismatch count plus the first failing vector.

Parameters:
- IN_W, 50, stimulus width (must be at most 64).
- OUT_W, 30, DUT result width.
- SETTLE, 2, cycles waited after each stimulus update before sampling (at least 1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin run; honoured only in IDLE or DONE.
- abort  input  1  terminate a run in progress.
- seed  input  64  LFSR seed; sampled on accepted start.
- num_vec  input  16  vector count; sampled on accepted start.
- stim  output  IN_W  stimulus to both DUTs (registered).
- ref_out  input  OUT_W  original-netlist result.
- opt_out  input  OUT_W  optimized-netlist result.
- busy  output  1  high in APPLY, SETTLE and COMPARE.
- done  output  1  high while in DONE.
- pass  output  1  done and mismatch_cnt==0 and run not aborted.
- mismatch_cnt  output  16  failing vectors; saturates at 16'hFFFF.
- first_fail_idx  output  16  index (0-based) of first failing vector.
- first_fail_stim  output  IN_W  stimulus of first failing vector.
- first_fail_diff  output  OUT_W  ref_out^opt_out of first failing vector.

Behaviour:
- Reset (asynchronous, any state, mid-run included):
  - State goes to IDLE.
  - stim, busy, done, pass, mismatch_cnt, all first_fail_* and internal idx/lfsr/settle counter go to 0.
  - No result survives reset.
- States: IDLE, APPLY, SETTLE, COMPARE, DONE.
- IDLE/DONE + start:
  - Latch num_vec.
  - Load lfsr with seed; seed==0 loads 64'h1 instead (lock-up avoidance).
  - Clear idx, mismatch_cnt, first_fail_*, pass and the abort flag.
  - Next state is APPLY, or DONE if num_vec==0 (pass=1, counts 0).
  - start is ignored while busy.
- APPLY (1 cycle): stim <= lfsr[IN_W-1:0]; settle counter <= SETTLE-1; next state SETTLE.
- SETTLE: lasts exactly SETTLE cycles (counter decrements to 0); next state COMPARE.
- COMPARE (1 cycle):
  - diff = ref_out ^ opt_out, sampled this cycle.
  - If diff != 0: mismatch_cnt increments, saturating.
  - If diff != 0 and this is the first failure of the run: capture idx, stim and diff into first_fail_*.
  - Always advance lfsr <= {lfsr[62:0], lfsr[63]^lfsr[62]^lfsr[60]^lfsr[59]}.
  - If idx == num_vec_latched-1, go to DONE; else idx <= idx+1 and go to APPLY.
- Latency:
  - Each vector takes 2+SETTLE cycles.
  - done rises num_vec*(2+SETTLE) rising edges after the edge that accepts start.
  - At that edge pass is valid, and stays valid with done.
- DONE:
  - Holds all results and stim until the next accepted start or reset.
  - start in DONE behaves exactly as start in IDLE.
- abort while busy:
  - Next state DONE; the abort flag is set and pass=0.
  - Results so far are retained.
  - A COMPARE in progress in that cycle is discarded: no count, no capture.
  - abort in IDLE/DONE is ignored.
- Simultaneous abort and start when busy: abort wins, start is ignored.
- num_vec=16'hFFFF runs all 65535 vectors; idx never wraps.

Test Plan:
- seed=1, num_vec=1, SETTLE=2, opt_out tied to ref_out:
  - stim=IN_W'h1 one edge after start; busy high edges 1-4.
  - done=1 and pass=1 exactly 4 edges after start; mismatch_cnt=0.
- seed=1, num_vec=3, bench forces opt_out=ref_out^30'h1 only while stim==2:
  - stim sequence 0x1, 0x2, 0x4.
  - mismatch_cnt=1, first_fail_idx=1, first_fail_stim=0x2, first_fail_diff=30'h1, pass=0.
  - done at edge 12.
- seed=0, num_vec=2: first stim=0x1, second stim=0x2 (zero-seed substitution).
- num_vec=0 with start: done=1, pass=1, busy never high, stim unchanged.
- Run num_vec=10 with a mismatch at every vector:
  - Assert abort in the SETTLE of vector 4: DONE next edge, pass=0, mismatch_cnt=4, first_fail_idx=0.
  - Then a new start clears all counts.
- rst asserted asynchronously mid-SETTLE:
  - All outputs read 0 before the next clk edge.
  - start afterward begins a clean run from the new seed.

Source files
------------

// File: rtl/dut_equiv_sequencer.sv
// Stimulus/compare sequencer for equivalence runs of an original and a reduced netlist.
// Drives LFSR vectors into both netlists, waits a settle time, then compares the results and tracks failures.
module dut_equiv_sequencer #(
    parameter int IN_W   = 50,
    parameter int OUT_W  = 30,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [63:0]      seed,
    input  logic [15:0]      num_vec,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] ref_out,
    input  logic [OUT_W-1:0] opt_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      mismatch_cnt,
    output logic [15:0]      first_fail_idx,
    output logic [IN_W-1:0]  first_fail_stim,
    output logic [OUT_W-1:0] first_fail_diff
);
    // state   | meaning
    // IDLE    | waiting for start
    // APPLY   | drive current LFSR value onto stim
    // SETTLE  | let both netlists settle
    // COMPARE | sample and compare ref_out/opt_out
    // DONE    | results held until next start
    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_COMPARE, S_DONE} state_t;

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [63:0]      r_lfsr;
    logic [15:0]      r_idx;
    logic [15:0]      r_num_vec;
    logic [SW-1:0]    r_settle;
    logic             r_aborted;
    logic             w_accept;
    logic             w_busy;
    logic             w_last;
    logic [OUT_W-1:0] w_diff;

    assign w_busy = (r_state == S_APPLY) || (r_state == S_SETTLE) || (r_state == S_COMPARE);
    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
    assign w_last = (r_idx == (r_num_vec - 16'd1));
    assign w_diff = ref_out ^ opt_out;

    assign busy = w_busy;
    assign done = (r_state == S_DONE);
    assign pass = done && (mismatch_cnt == 16'd0) && !r_aborted;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = (num_vec == 16'd0) ? S_DONE : S_APPLY;
            S_APPLY:        w_next = S_SETTLE;
            S_SETTLE:       if (r_settle == '0) w_next = S_COMPARE;
            S_COMPARE:      w_next = w_last ? S_DONE : S_APPLY;
            default:        w_next = S_IDLE;
        endcase
        // abort outranks every other transition, including a simultaneous start
        if (w_busy && abort) w_next = S_DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_lfsr          <= '0;
            r_idx           <= '0;
            r_num_vec       <= '0;
            r_settle        <= '0;
            r_aborted       <= 1'b0;
            stim            <= '0;
            mismatch_cnt    <= '0;
            first_fail_idx  <= '0;
            first_fail_stim <= '0;
            first_fail_diff <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_num_vec       <= num_vec;
                r_lfsr          <= (seed == 64'd0) ? 64'd1 : seed;
                r_idx           <= '0;
                r_aborted       <= 1'b0;
                mismatch_cnt    <= '0;
                first_fail_idx  <= '0;
                first_fail_stim <= '0;
                first_fail_diff <= '0;
            end else if (w_busy && abort) begin
                r_aborted <= 1'b1;
            end else begin
                case (r_state)
                    S_APPLY: begin
                        stim     <= r_lfsr[IN_W-1:0];
                        r_settle <= SW'(SETTLE - 1);
                    end
                    S_SETTLE: if (r_settle != '0) r_settle <= r_settle - SW'(1);
                    S_COMPARE: begin
                        if (w_diff != '0) begin
                            if (mismatch_cnt != 16'hFFFF) mismatch_cnt <= mismatch_cnt + 16'd1;
                            if (mismatch_cnt == 16'd0) begin
                                first_fail_idx  <= r_idx;
                                first_fail_stim <= stim;
                                first_fail_diff <= w_diff;
                            end
                        end
                        r_lfsr <= {r_lfsr[62:0], r_lfsr[63] ^ r_lfsr[62] ^ r_lfsr[60] ^ r_lfsr[59]};
                        if (!w_last) r_idx <= r_idx + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dut_equiv_sequencer.sv
// Self-checking bench for dut_equiv_sequencer: table of runs with a stimulus scoreboard,
// plus hand sequences for abort, zero-length runs and asynchronous reset.
module tb_dut_equiv_sequencer;
    localparam int IN_W = 50;
    localparam int OUT_W = 30;
    localparam int VEC_CYC = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [63:0]      seed;
    logic [15:0]      num_vec;
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] ref_out;
    logic [OUT_W-1:0] opt_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [15:0]      mismatch_cnt;
    logic [15:0]      first_fail_idx;
    logic [IN_W-1:0]  first_fail_stim;
    logic [OUT_W-1:0] first_fail_diff;

    int               mode;
    logic [OUT_W-1:0] dpat;
    logic             inj;

    int n_pass = 0;
    int n_total = 0;
    logic [IN_W-1:0] sb[$];

    typedef struct {
        logic [63:0]      seed;
        logic [15:0]      nv;
        int               mode;
        logic [OUT_W-1:0] dpat;
        logic [15:0]      cnt;
        logic [15:0]      ffi;
        logic [IN_W-1:0]  ffs;
        logic [OUT_W-1:0] ffd;
        logic             pass;
    } rec_t;

    rec_t tbl[4];

    always #5 clk = ~clk;

    // ref is a simple function of stim; mode 1 corrupts only stim==2, mode 2 corrupts every vector
    assign ref_out = stim[OUT_W-1:0];
    assign inj = (mode == 1) ? (stim == IN_W'(2)) : (mode == 2);
    assign opt_out = ref_out ^ (inj ? dpat : '0);

    dut_equiv_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed), .num_vec(num_vec),
        .stim(stim), .ref_out(ref_out), .opt_out(opt_out), .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .first_fail_idx(first_fail_idx),
        .first_fail_stim(first_fail_stim), .first_fail_diff(first_fail_diff)
    );

    function automatic logic [63:0] lfsr_next(input logic [63:0] x);
        return {x[62:0], x[63] ^ x[62] ^ x[60] ^ x[59]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic kick(input logic [63:0] s, input logic [15:0] nv);
        @(negedge clk);
        seed = s;
        num_vec = nv;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run(input rec_t r);
        logic [63:0] l;
        int edges;
        int lat;
        bit busy_ok;
        mode = r.mode;
        dpat = r.dpat;
        sb.delete();
        l = (r.seed == 64'd0) ? 64'd1 : r.seed;
        for (int k = 0; k < int'(r.nv); k++) begin
            sb.push_back(l[IN_W-1:0]);
            l = lfsr_next(l);
        end
        lat = int'(r.nv) * VEC_CYC;
        kick(r.seed, r.nv);
        busy_ok = (busy == (lat != 0));
        edges = 0;
        while (!done && edges < lat + 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges < lat && !busy) busy_ok = 0;
            if (edges >= lat && busy) busy_ok = 0;
            if (edges < lat && ((edges - 1) % VEC_CYC) == 0) begin
                if (sb.size() == 0) chk("stim_extra", stim, 0);
                else chk("stim", stim, sb.pop_front());
            end
        end
        chk("latency", edges, lat);
        chk("busy_window", busy_ok, 1);
        chk("done", done, 1);
        chk("pass", pass, r.pass);
        chk("mismatch_cnt", mismatch_cnt, r.cnt);
        chk("first_fail_idx", first_fail_idx, r.ffi);
        chk("first_fail_stim", first_fail_stim, r.ffs);
        chk("first_fail_diff", first_fail_diff, r.ffd);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        rec_t r;
        logic [IN_W-1:0] prev;

        tbl[0] = '{seed: 64'd1, nv: 16'd1, mode: 0, dpat: '0, cnt: 16'd0, ffi: 16'd0, ffs: '0, ffd: '0, pass: 1'b1};
        tbl[1] = '{seed: 64'd1, nv: 16'd3, mode: 1, dpat: 30'h1, cnt: 16'd1, ffi: 16'd1, ffs: 50'h2, ffd: 30'h1, pass: 1'b0};
        tbl[2] = '{seed: 64'd0, nv: 16'd2, mode: 0, dpat: '0, cnt: 16'd0, ffi: 16'd0, ffs: '0, ffd: '0, pass: 1'b1};
        tbl[3] = '{seed: 64'hDEADBEEF_CAFEF00D, nv: 16'd5, mode: 2, dpat: 30'h3, cnt: 16'd5, ffi: 16'd0,
                   ffs: 50'h1BEEFCAFEF00D, ffd: 30'h3, pass: 1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; seed = '0; num_vec = '0; mode = 0; dpat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stim", stim, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 4; i++) run(tbl[i]);

        // zero-length run from DONE after a failing run
        prev = stim;
        r = '{seed: 64'd7, nv: 16'd0, mode: 0, dpat: '0, cnt: 16'd0, ffi: 16'd0, ffs: '0, ffd: '0, pass: 1'b1};
        run(r);
        chk("nv0_stim_held", stim, prev);

        // abort in DONE is ignored
        @(negedge clk) abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_in_done_pass", pass, 1);
        chk("abort_in_done_done", done, 1);

        // abort during SETTLE of vector 4 with a stray start mid-run and a simultaneous start
        mode = 2; dpat = 30'h3;
        kick(64'h1234, 16'd10);
        repeat (9) @(posedge clk);
        #1 begin start = 1'b1; num_vec = 16'd1; end
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("abort_pre_busy", busy, 1);
        abort = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 begin abort = 1'b0; start = 1'b0; end
        chk("abort_done", done, 1);
        chk("abort_pass", pass, 0);
        chk("abort_cnt", mismatch_cnt, 4);
        chk("abort_ffi", first_fail_idx, 0);
        chk("abort_ffs", first_fail_stim, 50'h1234);
        chk("abort_ffd", first_fail_diff, 30'h3);
        @(posedge clk);
        #1 chk("abort_done_held", done, 1);

        // abort landing on a COMPARE discards that comparison
        kick(64'd1, 16'd10);
        repeat (7) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_cmp_cnt", mismatch_cnt, 1);
        chk("abort_cmp_done", done, 1);

        // fresh start after abort clears everything
        run(tbl[0]);

        // asynchronous reset mid-SETTLE with one mismatch already recorded
        mode = 2; dpat = 30'h5;
        kick(64'd1, 16'd3);
        repeat (5) @(posedge clk);
        #1 chk("pre_rst_cnt", mismatch_cnt, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_stim", stim, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_pass", pass, 0);
        chk("arst_cnt", mismatch_cnt, 0);
        chk("arst_ffi", first_fail_idx, 0);
        chk("arst_ffs", first_fail_stim, 0);
        chk("arst_ffd", first_fail_diff, 0);
        @(negedge clk) rst = 1'b0;
        r = '{seed: 64'd5, nv: 16'd1, mode: 0, dpat: '0, cnt: 16'd0, ffi: 16'd0, ffs: '0, ffd: '0, pass: 1'b1};
        run(r);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
